// File: rtl/gift_pkg.sv
// gift_pkg: screen geometry shared with the renderer, gift FSM encodings,
// and the load-time position clamps.
package gift_pkg;

  localparam int LEFT = 16;
  localparam int TOP  = 16;
  localparam int MAXX = 608;
  localparam int MAXY = 448;
  localparam int PD_H = 8;

  localparam int FALL_STEP_DEF = 2;
  localparam int PAD_HW_DEF    = 32;

  localparam logic [1:0] GIFT_IDLE   = 2'd0;
  localparam logic [1:0] GIFT_FALL   = 2'd1;
  localparam logic [1:0] GIFT_RETIRE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = GIFT_IDLE,
    ST_FALL   = GIFT_FALL,
    ST_RETIRE = GIFT_RETIRE
  } gift_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] kind;
  } gift_req_t;

  // Keep the whole gift sprite inside the playfield horizontally.
  function automatic logic [9:0] clamp_x(input logic [9:0] sx);
    logic [10:0] lo;
    logic [10:0] hi;
    logic [10:0] v;
    lo = 11'(LEFT + PD_H);
    hi = 11'(LEFT + MAXX - PD_H);
    v  = {1'b0, sx};
    if (v < lo) v = lo;
    else if (v > hi) v = hi;
    return v[9:0];
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] sy);
    logic [10:0] lo;
    logic [10:0] v;
    lo = 11'(TOP + PD_H);
    v  = {1'b0, sy};
    if (v < lo) v = lo;
    return v[9:0];
  endfunction

endpackage

// File: rtl/gift_lfsr.sv
// gift_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying
// random gift kinds. Only compiled when GIFT_RANDOM_KIND_EN is defined.
`ifdef GIFT_RANDOM_KIND_EN
module gift_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] rnd
);
  logic [15:0] sr;
  logic        fb;

  assign fb  = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
  assign rnd = sr[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= 16'hACE1;
    else        sr <= {sr[14:0], fb};
  end
endmodule
`endif

// File: rtl/gift_ctrl.sv
// gift_ctrl: owns the single falling power-up gift -- spawn, per-frame fall,
// paddle catch / floor miss. GIFT_RANDOM_KIND_EN selects LFSR-drawn kinds.
module gift_ctrl
  import gift_pkg::*;
#(
  parameter int FALL_STEP = FALL_STEP_DEF,
  parameter int PAD_HW    = PAD_HW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       clear,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [2:0] spawn_kind,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_top,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] kind,
  output logic       active,
  output logic       caught,
  output logic [2:0] caught_kind,
  output logic       missed,
  output logic       spawn_drop
);
  // state  | meaning
  // IDLE   | no gift on screen; launches the pending request or a new spawn
  // FALL   | gift on screen, drops FALL_STEP rows per frame_tick
  // RETIRE | one-cycle gap after a catch or miss before the next launch

  localparam logic [10:0] STEP11  = 11'(FALL_STEP);
  localparam logic [10:0] PDH11   = 11'(PD_H);
  localparam logic [10:0] HW11    = 11'(PAD_HW);
  localparam logic [10:0] FLOOR11 = 11'(TOP + MAXY);

  gift_state_e state, state_nxt;
  logic        pend_valid;
  gift_req_t   pend, req, src;
  logic        do_load, from_pend, do_store, do_drop;
  logic        do_catch, do_miss, do_move;
  logic [10:0] x11, y11, ny11, px11, pt11;
  logic        hit, floor_hit;
  logic [2:0]  load_kind;

  assign req = {spawn_x, spawn_y, spawn_kind};
  assign src = from_pend ? pend : req;

`ifdef GIFT_RANDOM_KIND_EN
  logic [2:0] rnd;
  gift_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .rnd(rnd));
  // kind 0 would render as "no gift", so it is folded onto kind 1
  assign load_kind = (rnd == 3'b000) ? 3'b001 : rnd;
`else
  assign load_kind = src.kind;
`endif

  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign px11 = {1'b0, paddle_x};
  assign pt11 = {1'b0, paddle_top};
  assign ny11 = y11 + STEP11;

  assign hit = (ny11 + PDH11 >= pt11) && (y11 + PDH11 <= pt11) &&
               (x11 + PDH11 + HW11 > px11) && (x11 < px11 + HW11 + PDH11);
  assign floor_hit = (ny11 + PDH11 >= FLOOR11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    from_pend = 1'b0;
    do_store  = 1'b0;
    do_drop   = 1'b0;
    do_catch  = 1'b0;
    do_miss   = 1'b0;
    do_move   = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            do_load   = 1'b1;
            from_pend = 1'b1;
            do_store  = spawn;
            state_nxt = ST_FALL;
          end else if (spawn) begin
            do_load   = 1'b1;
            state_nxt = ST_FALL;
          end
        end
        ST_FALL: begin
          if (frame_tick) begin
            if (hit) begin
              do_catch  = 1'b1;
              state_nxt = ST_RETIRE;
            end else if (floor_hit) begin
              do_miss   = 1'b1;
              state_nxt = ST_RETIRE;
            end else begin
              do_move = 1'b1;
            end
          end
        end
        ST_RETIRE: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
      // one-deep buffer while a gift is already in flight
      if (spawn && state != ST_IDLE) begin
        if (pend_valid) do_drop  = 1'b1;
        else            do_store = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (do_store) begin
      pend_valid <= 1'b1;
      pend       <= req;
    end else if (from_pend) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      kind        <= '0;
      active      <= 1'b0;
      caught      <= 1'b0;
      caught_kind <= '0;
      missed      <= 1'b0;
      spawn_drop  <= 1'b0;
    end else begin
      caught     <= 1'b0;
      missed     <= 1'b0;
      spawn_drop <= do_drop;
      if (clear) begin
        active <= 1'b0;
      end else begin
        if (do_load) begin
          x      <= clamp_x(src.x);
          y      <= clamp_y(src.y);
          kind   <= load_kind;
          active <= 1'b1;
        end
        if (do_catch) begin
          caught      <= 1'b1;
          caught_kind <= kind;
          active      <= 1'b0;
        end
        if (do_miss) begin
          missed <= 1'b1;
          active <= 1'b0;
        end
        if (do_move) y <= ny11[9:0];
      end
    end
  end

endmodule

// File: tb/tb_gift_ctrl.sv
// tb_gift_ctrl: scoreboard bench for gift_ctrl; expected launches and
// catch/miss/drop events are queued at stimulus time and popped by a monitor.
module tb_gift_ctrl;
  import gift_pkg::*;

  localparam int STEP = 2;
  localparam int HW   = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0, clear = 1'b0, spawn = 1'b0;
  logic [9:0] spawn_x = '0, spawn_y = '0, paddle_x = '0, paddle_top = '0;
  logic [2:0] spawn_kind = '0;
  logic [9:0] x, y;
  logic [2:0] kind, caught_kind;
  logic       active, caught, missed, spawn_drop;

  gift_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .clear(clear),
    .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_kind(spawn_kind),
    .paddle_x(paddle_x), .paddle_top(paddle_top),
    .x(x), .y(y), .kind(kind), .active(active), .caught(caught),
    .caught_kind(caught_kind), .missed(missed), .spawn_drop(spawn_drop)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int kind; } launch_t;
  typedef struct { bit is_catch; int kind; int y; } event_t;

  launch_t launch_q[$];
  event_t  event_q[$];
  int      drop_q[$];
  int      total = 0;
  int      passed = 0;
  int      last_caught_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // reference model: clamps and the frame-by-frame fall outcome
  function automatic int clampx(input int sx);
    int lo, hi;
    lo = LEFT + PD_H;
    hi = LEFT + MAXX - PD_H;
    return (sx < lo) ? lo : ((sx > hi) ? hi : sx);
  endfunction

  function automatic int clampy(input int sy);
    return (sy < TOP + PD_H) ? TOP + PD_H : sy;
  endfunction

  function automatic event_t predict(input int gx, input int gy, input int kd,
                                     input int px, input int pt);
    event_t e;
    int yy, ny;
    yy = gy;
    e.kind = kd;
    e.is_catch = 1'b0;
    e.y = gy;
    for (int f = 0; f < 4096; f++) begin
      ny = yy + STEP;
      if (ny + PD_H >= pt && yy + PD_H <= pt && gx + PD_H + HW > px && gx < px + HW + PD_H) begin
        e.is_catch = 1'b1;
        e.y = yy;
        return e;
      end
      if (ny + PD_H >= TOP + MAXY) begin
        e.y = yy;
        return e;
      end
      yy = ny;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn_req(input int sx, input int sy, input int sk,
                           input bit accept, input bit with_tick);
    launch_t l;
    spawn = 1'b1;
    spawn_x = 10'(sx);
    spawn_y = 10'(sy);
    spawn_kind = 3'(sk);
    frame_tick = with_tick;
    if (accept) begin
      l.x = clampx(sx);
      l.y = clampy(sy);
      l.kind = sk;
      launch_q.push_back(l);
      event_q.push_back(predict(l.x, l.y, sk, int'(paddle_x), int'(paddle_top)));
    end else begin
      drop_q.push_back(sk);
    end
    step();
    spawn = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic do_clear(input bit with_spawn);
    clear = 1'b1;
    spawn = with_spawn;
    spawn_x = 10'(LEFT + 300);
    spawn_y = 10'(TOP + 40);
    spawn_kind = 3'd7;
    step();
    clear = 1'b0;
    spawn = 1'b0;
    launch_q.delete();
    event_q.delete();
  endtask

  task automatic frame(output bit c, output bit m, output bit a1, output bit a2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    c = caught;
    m = missed;
    step();
    a1 = active;
    step();
    a2 = active;
  endtask

  task automatic wait_event(output bit m, output bit a1, output bit a2);
    bit c;
    m = 1'b0; a1 = 1'b0; a2 = 1'b0; c = 1'b0;
    for (int i = 0; i < 600; i++) begin
      frame(c, m, a1, a2);
      if (c || m) return;
    end
    fail("event_timeout");
  endtask

  task automatic run_until_empty();
    bit m, a1, a2;
    for (int g = 0; g < 8 && event_q.size() > 0; g++) wait_event(m, a1, a2);
    check("events_drained", event_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_kind"}, int'(kind), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_caught"}, int'(caught), 0);
    check({tag, "_caught_kind"}, int'(caught_kind), 0);
    check({tag, "_missed"}, int'(missed), 0);
    check({tag, "_drop"}, int'(spawn_drop), 0);
  endtask

  // monitor: compares every launch and every output pulse with the queues
  initial begin : monitor
    bit prev_act;
    launch_t l;
    event_t e;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_act = 1'b0;
        continue;
      end
      if (active && !prev_act) begin
        if (launch_q.size() == 0) fail("unexpected_launch");
        else begin
          l = launch_q.pop_front();
          check("launch_x", int'(x), l.x);
          check("launch_y", int'(y), l.y);
          check("launch_kind", int'(kind), l.kind);
        end
      end
      prev_act = active;
      if (caught || missed) begin
        if (event_q.size() == 0) fail("unexpected_retire");
        else begin
          e = event_q.pop_front();
          check("retire_caught", int'(caught), int'(e.is_catch));
          check("retire_missed", int'(missed), int'(!e.is_catch));
          check("retire_y", int'(y), e.y);
          check("retire_active", int'(active), 0);
          if (e.is_catch) begin
            last_caught_exp = e.kind;
            check("caught_kind", int'(caught_kind), e.kind);
          end
        end
      end
      if (spawn_drop) begin
        if (drop_q.size() == 0) fail("unexpected_drop");
        else void'(drop_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit c, m, a1, a2;
    int pulses, gx, px, sx, sy;

    #2 rst_n = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // floor miss with the paddle far away
    paddle_x = 10'(LEFT + 500);
    paddle_top = 10'(400);
    spawn_req(LEFT + 100, TOP + 20, 3, 1'b1, 1'b0);
    check("s1_active", int'(active), 1);
    check("s1_x", int'(x), LEFT + 100);
    check("s1_y", int'(y), TOP + 20);
    frame(c, m, a1, a2);
    check("s1_fall_y", int'(y), TOP + 22);
    wait_event(m, a1, a2);
    check("s1_missed", int'(m), 1);
    check("s1_active_after", int'(active), 0);
    check("s1_drained", event_q.size(), 0);

    // catch on the third frame
    paddle_x = 10'(LEFT + 110);
    paddle_top = 10'(TOP + 20 + PD_H + 6);
    spawn_req(LEFT + 100, TOP + 20, 5, 1'b1, 1'b0);
    frame(c, m, a1, a2);
    check("s2_f1_caught", int'(c), 0);
    frame(c, m, a1, a2);
    check("s2_f2_caught", int'(c), 0);
    frame(c, m, a1, a2);
    check("s2_f3_caught", int'(c), 1);
    check("s2_f3_missed", int'(m), 0);
    check("s2_caught_kind", int'(caught_kind), 5);
    check("s2_active", int'(active), 0);

    // edge clamps
    paddle_x = 10'(LEFT + 500);
    paddle_top = 10'(400);
    spawn_req(0, 0, 1, 1'b1, 1'b0);
    step();
    check("s3_x_lo", int'(x), LEFT + PD_H);
    check("s3_y_lo", int'(y), TOP + PD_H);
    do_clear(1'b0);
    spawn_req(1023, 100, 2, 1'b1, 1'b0);
    step();
    check("s3_x_hi", int'(x), LEFT + MAXX - PD_H);
    do_clear(1'b0);

    // buffering: A flies, B waits, C is dropped
    spawn_req(LEFT + 100, TOP + 300, 1, 1'b1, 1'b0);
    spawn_req(LEFT + 50, TOP + 200, 6, 1'b1, 1'b0);
    spawn_req(LEFT + 60, TOP + 10, 7, 1'b0, 1'b0);
    step();
    wait_event(m, a1, a2);
    check("s4_a_missed", int'(m), 1);
    check("s4_gap_active", int'(a1), 0);
    check("s4_b_active", int'(a2), 1);
    check("s4_b_kind", int'(kind), 6);
    run_until_empty();

    // clear mid-fall with B pending and a spawn in the same cycle
    spawn_req(LEFT + 100, TOP + 100, 4, 1'b1, 1'b0);
    frame(c, m, a1, a2);
    spawn_req(LEFT + 200, TOP + 50, 3, 1'b1, 1'b0);
    do_clear(1'b1);
    check("s5_active", int'(active), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      frame(c, m, a1, a2);
      pulses += int'(c) + int'(m) + int'(a2);
    end
    check("s5_quiet", pulses, 0);
    check("s5_caught_kind_kept", int'(caught_kind), last_caught_exp);

    // randomized gifts around the paddle
    for (int g = 0; g < 25; g++) begin
      sx = int'($urandom_range(0, 1023));
      sy = int'($urandom_range(0, 500));
      gx = clampx(sx);
      px = gx + int'($urandom_range(0, 100)) - 50;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      paddle_x = 10'(px);
      paddle_top = 10'($urandom_range(TOP + 20, TOP + MAXY));
      spawn_req(sx, sy, int'($urandom_range(0, 7)), 1'b1, 1'(($urandom_range(0, 1))));
      run_until_empty();
      step();
    end

    // asynchronous reset mid-fall
    paddle_x = 10'(LEFT + 500);
    paddle_top = 10'(400);
    spawn_req(LEFT + 150, TOP + 60, 2, 1'b1, 1'b0);
    frame(c, m, a1, a2);
    frame(c, m, a1, a2);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    launch_q.delete();
    event_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    spawn_req(LEFT + 200, TOP + 50, 4, 1'b1, 1'b0);
    check("s7_active", int'(active), 1);
    check("s7_y", int'(y), TOP + 50);
    run_until_empty();

    step();
    step();
    check("launch_q_empty", launch_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
